// File: rtl/cgra0_conf_pkg.sv
// ============================================================================
// Module      : cgra0_conf_pkg
// Description : Shared definitions for the cgra0 configuration bus: record
//               type codes, header/bus field layout, the NOP word and the
//               writer FSM state encoding. Also used by the per-PE reader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cgra0_conf_pkg;

    // Field widths
    localparam int c_TYPE_W   = 4;
    localparam int c_PE_W     = 8;
    localparam int c_THREAD_W = 3;
    localparam int c_ADDR_W   = 4;
    localparam int c_LEN_W    = 8;
    localparam int c_DATA_W   = 32;
    localparam int c_BUS_W    = 64;

    // Bus word field offsets (LSB positions); bits [44:32] are always zero
    localparam int c_BUS_TYPE_LSB   = 60;
    localparam int c_BUS_PE_LSB     = 52;
    localparam int c_BUS_THREAD_LSB = 49;
    localparam int c_BUS_ADDR_LSB   = 45;
    localparam int c_BUS_DATA_LSB   = 0;

    // Header beat field offsets (LSB positions); bits [4:0] are ignored
    localparam int c_HDR_TYPE_LSB   = 28;
    localparam int c_HDR_PE_LSB     = 20;
    localparam int c_HDR_THREAD_LSB = 17;
    localparam int c_HDR_ADDR_LSB   = 13;
    localparam int c_HDR_LEN_LSB    = 5;

    // Record type codes; 8..14 are illegal
    localparam logic [c_TYPE_W-1:0] c_TYPE_NOP      = 4'd0;
    localparam logic [c_TYPE_W-1:0] c_TYPE_INST     = 4'd1;
    localparam logic [c_TYPE_W-1:0] c_TYPE_CONST    = 4'd2;
    localparam logic [c_TYPE_W-1:0] c_TYPE_PC_MAX   = 4'd3;
    localparam logic [c_TYPE_W-1:0] c_TYPE_PC_LOOP  = 4'd4;
    localparam logic [c_TYPE_W-1:0] c_TYPE_IGNORE   = 4'd5;
    localparam logic [c_TYPE_W-1:0] c_TYPE_QTD_LOW  = 4'd6;
    localparam logic [c_TYPE_W-1:0] c_TYPE_QTD_HIGH = 4'd7;
    localparam logic [c_TYPE_W-1:0] c_TYPE_END      = 4'd15;

    // All-zero bus word is seen as NOP by every PE
    localparam logic [c_BUS_W-1:0] c_NOP_WORD = '0;

    // Writer FSM states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_PAYLOAD = 2'd2
    } conf_wr_state_e;

    // True for the reserved type codes 8..14
    function automatic logic is_illegal_type(input logic [c_TYPE_W-1:0] t);
        return (t >= 4'd8) && (t <= 4'd14);
    endfunction

    // Assemble one broadcast word from its fields
    function automatic logic [c_BUS_W-1:0] pack_bus_word(
        input logic [c_TYPE_W-1:0]   t,
        input logic [c_PE_W-1:0]     pe,
        input logic [c_THREAD_W-1:0] thr,
        input logic [c_ADDR_W-1:0]   addr,
        input logic [c_DATA_W-1:0]   data
    );
        logic [c_BUS_W-1:0] w;
        w = c_NOP_WORD;
        w[c_BUS_TYPE_LSB   +: c_TYPE_W]   = t;
        w[c_BUS_PE_LSB     +: c_PE_W]     = pe;
        w[c_BUS_THREAD_LSB +: c_THREAD_W] = thr;
        w[c_BUS_ADDR_LSB   +: c_ADDR_W]   = addr;
        w[c_BUS_DATA_LSB   +: c_DATA_W]   = data;
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cgra0_conf_writer.sv
// ============================================================================
// Module      : cgra0_conf_writer
// Description : Configuration bus transmitter. Takes a 32-bit valid/ready
//               host stream of header + payload records and broadcasts one
//               registered 64-bit word per payload beat, auto-incrementing
//               the target address (mod 16). END record pulses done.
//               Optional macro CGRA0_CONF_WRITER_CHECK_EN adds the sticky
//               o_err flag and suppresses illegal records on the bus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cgra0_conf_writer
    import cgra0_conf_pkg::*;
#(
    parameter int NUM_PE = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic [c_DATA_W-1:0] i_conf_in_data,
    input  logic                i_conf_in_valid,
    output logic                o_conf_in_ready,
    output logic [c_BUS_W-1:0]  o_conf_bus_out,
    output logic                o_busy,
`ifdef CGRA0_CONF_WRITER_CHECK_EN
    output logic                o_err,
`endif
    output logic                o_done
);

    conf_wr_state_e            r_state;
    conf_wr_state_e            w_state_nxt;
    logic [c_TYPE_W-1:0]       r_type;
    logic [c_PE_W-1:0]         r_pe;
    logic [c_THREAD_W-1:0]     r_thread;
    logic [c_ADDR_W-1:0]       r_addr;
    logic [c_LEN_W-1:0]        r_cnt;
    logic [c_BUS_W-1:0]        r_bus;
    logic                      r_done;

    logic                      w_accept;
    logic                      w_hdr_accept;
    logic                      w_beat_accept;
    logic                      w_hdr_opens_burst;
    logic                      w_beat_emit;
    logic [c_TYPE_W-1:0]       w_hdr_type;
    logic [c_PE_W-1:0]         w_hdr_pe;
    logic [c_THREAD_W-1:0]     w_hdr_thread;
    logic [c_ADDR_W-1:0]       w_hdr_addr;
    logic [c_LEN_W-1:0]        w_hdr_lenm1;

    // Header field extraction straight from the stream
    assign w_hdr_type   = i_conf_in_data[c_HDR_TYPE_LSB   +: c_TYPE_W];
    assign w_hdr_pe     = i_conf_in_data[c_HDR_PE_LSB     +: c_PE_W];
    assign w_hdr_thread = i_conf_in_data[c_HDR_THREAD_LSB +: c_THREAD_W];
    assign w_hdr_addr   = i_conf_in_data[c_HDR_ADDR_LSB   +: c_ADDR_W];
    assign w_hdr_lenm1  = i_conf_in_data[c_HDR_LEN_LSB    +: c_LEN_W];

    // Ready/busy decode the registered state, so both rise the cycle after start
    assign o_conf_in_ready = (r_state != ST_IDLE);
    assign o_busy          = (r_state != ST_IDLE);
    assign o_conf_bus_out  = r_bus;
    assign o_done          = r_done;

    assign w_accept          = i_conf_in_valid && o_conf_in_ready;
    assign w_hdr_accept      = w_accept && (r_state == ST_HEADER);
    assign w_beat_accept     = w_accept && (r_state == ST_PAYLOAD);
    assign w_hdr_opens_burst = w_hdr_accept && (w_hdr_type != c_TYPE_NOP)
                                            && (w_hdr_type != c_TYPE_END);

`ifdef CGRA0_CONF_WRITER_CHECK_EN
    localparam logic [c_PE_W:0] c_NUM_PE = (c_PE_W + 1)'(NUM_PE);

    logic r_drop;
    logic r_err;
    logic w_hdr_illegal;

    assign w_hdr_illegal = is_illegal_type(w_hdr_type) || ({1'b0, w_hdr_pe} >= c_NUM_PE);
    assign w_beat_emit   = w_beat_accept && !r_drop;
    assign o_err         = r_err;

    // Illegal burst tracking: drop its payload, latch the sticky error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop <= 1'b0;
            r_err  <= 1'b0;
        end else if (w_hdr_opens_burst) begin
            r_drop <= w_hdr_illegal;
            r_err  <= r_err | w_hdr_illegal;
        end
    end
`else
    // Illegal records are forwarded like any other burst
    assign w_beat_emit = w_beat_accept;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = ST_HEADER;
                end
            end
            ST_HEADER: begin
                if (w_hdr_accept && (w_hdr_type == c_TYPE_END)) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_hdr_opens_burst) begin
                    w_state_nxt = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (w_beat_accept && (r_cnt == '0)) begin
                    w_state_nxt = ST_HEADER;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Burst context: fields latched from the header, address/counter stepped per beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_type   <= c_TYPE_NOP;
            r_pe     <= '0;
            r_thread <= '0;
            r_addr   <= '0;
            r_cnt    <= '0;
        end else if (w_hdr_opens_burst) begin
            r_type   <= w_hdr_type;
            r_pe     <= w_hdr_pe;
            r_thread <= w_hdr_thread;
            r_addr   <= w_hdr_addr;
            r_cnt    <= w_hdr_lenm1;
        end else if (w_beat_accept) begin
            r_addr   <= r_addr + 1'b1;
            r_cnt    <= r_cnt - 1'b1;
        end
    end

    // Registered bus word: one cycle per accepted payload beat, NOP otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bus <= c_NOP_WORD;
        end else if (w_beat_emit) begin
            r_bus <= pack_bus_word(r_type, r_pe, r_thread, r_addr, i_conf_in_data);
        end else begin
            r_bus <= c_NOP_WORD;
        end
    end

    // End-of-configuration pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_hdr_accept && (w_hdr_type == c_TYPE_END);
        end
    end

endmodule

`default_nettype wire
